bist_controller: RTL
====================

Name: bist_controller

Overview:
- Sequences a built-in self-test run around the 3-bit Fibonacci pattern LFSR, the circuit under test (CUT) and its response MISR.
- Holds the LFSR in reset while idle, then runs two pattern phases, one per feedback polynomial selected by the LFSR Seed input.
- Enables MISR compaction, flushes the last response, compares the final signature with a golden value, and reports pass/fail.
- Sits between the test-access logic (Start/Abort) and the LFSR/CUT-mux/MISR datapath.

Parameters:
- N_PAT1, 7, patterns applied in phase 1 (Seed_sel=1); legal range 1..2^CNT_W.
- N_PAT2, 7, patterns applied in phase 2 (Seed_sel=0, reseed polynomial); legal range 1..2^CNT_W.
- CNT_W, 4, pattern counter width.
- SIG_W, 3, MISR signature width.
- GOLDEN, 3'b101, expected fault-free signature (SIG_W bits).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- Start  in  1  level; sampled only in IDLE; launches a run.
- Abort  in  1  level; terminates a run from any non-IDLE state.
- Sig_in  in  SIG_W  current MISR signature.
- Lfsr_rst  out  1  active-high reset to the LFSR (forces 111).
- Seed_sel  out  1  LFSR Seed input: 1 = phase-1 polynomial, 0 = reseed polynomial.
- Tst_mode  out  1  CUT input mux select: 1 = LFSR patterns, 0 = functional inputs.
- Misr_en  out  1  MISR capture enable.
- Misr_clr  out  1  MISR synchronous clear.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle pulse at the end of a completed run.
- Pass  out  1  registered result; valid from Done and held until the next Start or reset.

Behaviour:
- FSM states: IDLE, INIT, PHASE1, PHASE2, FLUSH, COMPARE, DONE. State and the CNT_W-bit counter are registered.
- All outputs except Pass are Moore decodes of the state.
- On reset (RST=0 at an edge), from any state, including mid-run:
  - state=IDLE, counter=0, Pass=0.
  - Outputs: Lfsr_rst=1, Seed_sel=1, Tst_mode=0, Misr_en=0, Misr_clr=0, Busy=0, Done=0.
- IDLE:
  - Outputs: Lfsr_rst=1, Seed_sel=1, Tst_mode=0, Busy=0.
  - Start=1 -> INIT; Pass cleared to 0 on the same edge.
- INIT, 1 cycle:
  - Outputs: Lfsr_rst=1, Misr_clr=1, Tst_mode=1, Busy=1.
  - Counter cleared to 0. Next state PHASE1.
- PHASE1:
  - Outputs: Lfsr_rst=0, Seed_sel=1, Tst_mode=1, Misr_en=1, Busy=1.
  - Counter increments each cycle.
  - When counter==N_PAT1-1: counter resets to 0 and the next state is PHASE2. The phase lasts exactly N_PAT1 cycles.
- PHASE2:
  - Outputs: as PHASE1 but Seed_sel=0. The LFSR is not reset; it continues from its current state.
  - When counter==N_PAT2-1: next state FLUSH. The phase lasts exactly N_PAT2 cycles.
- FLUSH, 1 cycle:
  - Outputs: Tst_mode=1, Misr_en=1, Seed_sel=0, Lfsr_rst=0.
  - Captures the CUT response to the final pattern (the CUT has one registered stage).
- COMPARE, 1 cycle:
  - Outputs: Misr_en=0, Tst_mode=0, Lfsr_rst=1.
  - On the exit edge, Pass <= (Sig_in==GOLDEN).
- DONE, 1 cycle:
  - Outputs: Done=1, Busy=0. Next state is always IDLE.
  - Start in DONE is ignored; it must be held or re-asserted in IDLE.
- Latency: with Start sampled at edge 0, Done is high in cycle N_PAT1+N_PAT2+4 (18 with defaults). Pass is valid in that same cycle.
- Start while Busy: ignored.
- Abort=1 in INIT..COMPARE:
  - Next state IDLE, Pass=0, no Done pulse.
  - Abort outranks every other transition, including a counter terminal count on the same edge.
- Abort in IDLE or DONE: no effect.
- Counter never exceeds max(N_PAT1,N_PAT2)-1. No wrap-around occurs for legal parameters.
- Start and RST=0 on the same edge: reset wins.

Test Plan:
- Reset, then Start pulse with Sig_in tied to 3'b101:
  - Lfsr_rst=1 in cycle 1, Seed_sel=1 for cycles 2-8, Seed_sel=0 for cycles 9-16.
  - Misr_en=1 for cycles 2-16, Done=1 only in cycle 18, Pass=1.
- Same run with Sig_in=3'b100 -> Done in cycle 18, Pass=0. A new Start clears Pass in the following cycle.
- Abort=1 in cycle 10 (PHASE2) -> IDLE at cycle 11, Lfsr_rst=1, Busy=0, no Done, Pass=0.
- Start held high continuously -> back-to-back runs with Done every 19 cycles. Start during Busy does not restart the counter.
- RST=0 during PHASE1 (cycle 5) -> next cycle all outputs at reset values. Start afterwards yields a normal 18-cycle run.
- N_PAT1=1, N_PAT2=16 (CNT_W=4) -> PHASE1 lasts 1 cycle, PHASE2 lasts 16 cycles, Done in cycle 21, counter never wraps.

Source files
------------

// File: rtl/bist_controller_if.sv
// rtl/bist_controller_if.sv - BIST controller test-access and datapath control bundle
interface bist_controller_if #(
    parameter int SIG_W = 3
);
    logic             Start;
    logic             Abort;
    logic [SIG_W-1:0] Sig_in;
    logic             Lfsr_rst;
    logic             Seed_sel;
    logic             Tst_mode;
    logic             Misr_en;
    logic             Misr_clr;
    logic             Busy;
    logic             Done;
    logic             Pass;

    modport master (
        output Start, Abort, Sig_in,
        input  Lfsr_rst, Seed_sel, Tst_mode, Misr_en, Misr_clr, Busy, Done, Pass
    );

    modport slave (
        input  Start, Abort, Sig_in,
        output Lfsr_rst, Seed_sel, Tst_mode, Misr_en, Misr_clr, Busy, Done, Pass
    );
endinterface

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - LFSR/MISR built-in self-test run sequencer
module bist_controller #(
    parameter int               N_PAT1 = 7,
    parameter int               N_PAT2 = 7,
    parameter int               CNT_W  = 4,
    parameter int               SIG_W  = 3,
    parameter logic [SIG_W-1:0] GOLDEN = 3'b101
) (
    input  logic             CLK,
    input  logic             RST,
    bist_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PHASE1,
        PHASE2,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    // Terminal counts; N_PAT up to 2^CNT_W still fits once decremented.
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(N_PAT1 - 1);
    localparam logic [CNT_W-1:0] LAST2 = CNT_W'(N_PAT2 - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               pass_r;
    logic               pass_nxt;
    logic               abortable;

    // State, pattern counter and result register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            pass_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pass_r <= pass_nxt;
        end
    end

    // Next-state, counter and result update; Abort overrides everything in a live run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pass_nxt  = pass_r;
        abortable = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.Start) begin
                    state_nxt = INIT;
                    pass_nxt  = 1'b0;
                end
            end
            INIT: begin
                abortable = 1'b1;
                cnt_nxt   = '0;
                state_nxt = PHASE1;
            end
            PHASE1: begin
                abortable = 1'b1;
                if (cnt == LAST1) begin
                    cnt_nxt   = '0;
                    state_nxt = PHASE2;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PHASE2: begin
                abortable = 1'b1;
                if (cnt == LAST2) begin
                    cnt_nxt   = '0;
                    state_nxt = FLUSH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FLUSH: begin
                abortable = 1'b1;
                state_nxt = COMPARE;
            end
            COMPARE: begin
                abortable = 1'b1;
                pass_nxt  = (bus.Sig_in == GOLDEN);
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (bus.Abort && abortable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pass_nxt  = 1'b0;
        end
    end

    // Moore decode of the datapath controls from the current state.
    always_comb begin
        bus.Lfsr_rst = 1'b1;
        bus.Seed_sel = 1'b1;
        bus.Tst_mode = 1'b0;
        bus.Misr_en  = 1'b0;
        bus.Misr_clr = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        case (state)
            IDLE: begin
            end
            INIT: begin
                bus.Misr_clr = 1'b1;
                bus.Tst_mode = 1'b1;
                bus.Busy     = 1'b1;
            end
            PHASE1: begin
                bus.Lfsr_rst = 1'b0;
                bus.Tst_mode = 1'b1;
                bus.Misr_en  = 1'b1;
                bus.Busy     = 1'b1;
            end
            PHASE2, FLUSH: begin
                bus.Lfsr_rst = 1'b0;
                bus.Seed_sel = 1'b0;
                bus.Tst_mode = 1'b1;
                bus.Misr_en  = 1'b1;
                bus.Busy     = 1'b1;
            end
            COMPARE: begin
                bus.Busy = 1'b1;
            end
            DONE: begin
                bus.Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Result is a register, not a state decode, so it survives into IDLE.
    always_comb begin
        bus.Pass = pass_r;
    end

endmodule
